// File: rtl/bist_pkg.sv
// Shared types and defaults for the full-adder BIST sequencer.
// Optional abort input enabled by defining BIST_ABORT_EN.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int SIG_WIDTH_DEF = 4;

  localparam logic [SIG_WIDTH_DEF-1:0] GOLDEN_SIG_DEF = 4'b1011;

endpackage

// File: rtl/bist_pattern_counter.sv
// Loadable up-counter with terminal-count flag used as the
// BIST pattern index.
module bist_pattern_counter #(
  parameter int CW   = 3,
  parameter int LAST = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          last
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == CW'(LAST));

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: clear/seed, run, capture MISR signature, compare.
// Define BIST_ABORT_EN to add the abort input.
module bist_controller
  import bist_pkg::*;
#(
  parameter int SIG_WIDTH = SIG_WIDTH_DEF,
  parameter int PATTERN_COUNT = 7,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = GOLDEN_SIG_DEF,
  localparam int CW = $clog2(PATTERN_COUNT + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
`ifdef BIST_ABORT_EN
  input  logic                 abort,
`endif
  input  logic [SIG_WIDTH-1:0] signature,
  output logic                 tpg_seed,
  output logic                 tpg_enable,
  output logic                 ora_clear,
  output logic                 ora_enable,
  output logic [CW-1:0]        pattern_index,
  output logic                 busy,
  output logic                 done,
  output logic                 pass
);

  state_t state_q;
  state_t nxt;

  logic                 last;
  logic                 cnt_load;
  logic                 cnt_en;
  logic                 abort_hit;
  logic [SIG_WIDTH-1:0] captured;

`ifdef BIST_ABORT_EN
  assign abort_hit = abort &&
    ((state_q == CLEAR) ||
     (state_q == RUN) ||
     (state_q == CAPTURE));
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= nxt;
    end
  end

  always_comb begin
    nxt = state_q;
    unique case (state_q)
      IDLE:    if (start) nxt = CLEAR;
      CLEAR:   nxt = RUN;
      RUN:     if (last) nxt = CAPTURE;
      CAPTURE: nxt = DONE;
      DONE:    if (start) nxt = CLEAR;
      default: nxt = IDLE;
    endcase
    if (abort_hit) nxt = IDLE;
  end

  // Index is zeroed on entry to CLEAR (and IDLE) and parks at the
  // terminal count once RUN has covered every pattern.
  assign cnt_load = (nxt == CLEAR) || (nxt == IDLE);
  assign cnt_en   = (state_q == RUN) && !last;

  bist_pattern_counter #(
    .CW   (CW),
    .LAST (PATTERN_COUNT - 1)
  ) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .load   (cnt_load),
    .enable (cnt_en),
    .count  (pattern_index),
    .last   (last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      captured <= '0;
    end else if ((state_q == CAPTURE) && !abort_hit) begin
      captured <= signature;
    end
  end

  assign tpg_seed   = (state_q == CLEAR);
  assign ora_clear  = (state_q == CLEAR);
  assign tpg_enable = (state_q == RUN);
  assign ora_enable = (state_q == RUN);
  assign busy       = (state_q == CLEAR) ||
                      (state_q == RUN) ||
                      (state_q == CAPTURE);
  assign done       = (state_q == DONE);
  assign pass       = done && (captured == GOLDEN_SIG);

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: vector table, corner sequences and
// random stimulus against a queue-based expected-trace model.
module tb_bist_controller;

  localparam int PC = 7;
  localparam logic [3:0] GOLD = 4'b1011;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] signature = 4'h0;
`ifdef BIST_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       tpg_seed, tpg_enable, ora_clear, ora_enable;
  logic [2:0] pattern_index;
  logic       busy, done, pass;

  int passed = 0;
  int total  = 0;

  bist_controller dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
`ifdef BIST_ABORT_EN
    .abort         (abort),
`endif
    .signature     (signature),
    .tpg_seed      (tpg_seed),
    .tpg_enable    (tpg_enable),
    .ora_clear     (ora_clear),
    .ora_enable    (ora_enable),
    .pattern_index (pattern_index),
    .busy          (busy),
    .done          (done),
    .pass          (pass)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       seed;
    logic       clr;
    logic       ten;
    logic       oen;
    logic [2:0] idx;
    logic       bsy;
    logic       dn;
    logic       ps;
  } obs_t;

  typedef struct {
    logic [3:0] sg;
    int         extra;
    logic       ep;
  } vec_t;

  function automatic obs_t sample();
    return '{tpg_seed, ora_clear, tpg_enable, ora_enable,
             pattern_index, busy, done, pass};
  endfunction

  function automatic obs_t mk(logic s, logic r, logic [2:0] i,
                              logic b, logic d, logic p);
    return '{s, s, r, r, i, b, d, p};
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run_one(input logic [3:0] sg, input int extra,
                         input logic ep, input string nm);
    int e, seeds, clrs, ens, bad_idx, lat;
    e = 0; seeds = 0; clrs = 0; ens = 0; bad_idx = 0; lat = -1;
    @(negedge clock);
    start = 1'b1;
    signature = ~sg;
    while (lat < 0 && e < 40) begin
      @(negedge clock);
      e++;
      start = (extra > 0 && e == extra + 1);
      if (tpg_seed) seeds++;
      if (ora_clear) clrs++;
      if (ora_enable) begin
        if (pattern_index != 3'(ens)) bad_idx++;
        ens++;
      end
      if (done) lat = e;
      signature = (e == PC + 2) ? sg : ~sg;
    end
    start = 1'b0;
    check({nm, "_latency"}, lat, PC + 3);
    check({nm, "_seed_cycles"}, seeds, 1);
    check({nm, "_clear_cycles"}, clrs, 1);
    check({nm, "_enable_cycles"}, ens, PC);
    check({nm, "_index_steps"}, bad_idx, 0);
    check({nm, "_pass"}, pass, ep);
    check({nm, "_done_index"}, pattern_index, PC - 1);
    check({nm, "_busy_in_done"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    obs_t q[$];
    obs_t cur, nx;
    int bad;
    logic st, ab;
    logic [3:0] sg;

    tbl[0] = '{4'b1011, 0, 1'b1};
    tbl[1] = '{4'b0110, 0, 1'b0};
    tbl[2] = '{4'b1011, 3, 1'b1};
    tbl[3] = '{4'b0000, 0, 1'b0};
    tbl[4] = '{4'b1010, 3, 1'b0};
    tbl[5] = '{4'b1011, 0, 1'b1};

    #1;
    check("in_reset", sample(), 0);
    #9;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (sample() != 0) bad++;
    end
    check("idle_20_cycles", bad, 0);

    for (int i = 0; i < 6; i++)
      run_one(tbl[i].sg, tbl[i].extra, tbl[i].ep,
              $sformatf("vec%0d", i));

    @(negedge clock);
    start = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clock);
      start = 1'b0;
    end
    check("rst_mid_in_run", ora_enable, 1);
    #2 reset = 1'b1;
    #1 check("rst_mid_async", sample(), 0);
    @(negedge clock);
    check("rst_mid_held", sample(), 0);
    reset = 1'b0;
    run_one(GOLD, 0, 1'b1, "post_rst");

`ifdef BIST_ABORT_EN
    @(negedge clock);
    start = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clock);
      start = 1'b0;
    end
    check("abort_run_idx", pattern_index, 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_to_idle", sample(), 0);
    run_one(GOLD, 0, 1'b1, "abort_rerun");
`endif

    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    cur = '0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      check($sformatf("rand%0d", i), sample(), cur);
      st = ($urandom_range(7) == 0);
      sg = ($urandom_range(2) == 0) ? GOLD : 4'($urandom);
      ab = 1'b0;
`ifdef BIST_ABORT_EN
      ab = ($urandom_range(24) == 0);
      abort = ab;
`endif
      start = st;
      signature = sg;
      if (cur.bsy && ab) begin
        q.delete();
        nx = '0;
      end else if (cur.bsy && !cur.seed && !cur.ten) begin
        nx = mk(0, 0, 3'(PC - 1), 0, 1, sg == GOLD);
      end else if (q.size() > 0) begin
        nx = q.pop_front();
      end else if (st) begin
        q.push_back(mk(1, 0, 3'd0, 1, 0, 0));
        for (int k = 0; k < PC; k++)
          q.push_back(mk(0, 1, 3'(k), 1, 0, 0));
        q.push_back(mk(0, 0, 3'(PC - 1), 1, 0, 0));
        nx = q.pop_front();
      end else begin
        nx = cur;
      end
      cur = nx;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
